vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA sync/timing generator; successor to the fixed 640x480 driver.
- Any standard mode (640x480@60, 800x600@72, 1024x768@60, ...) is selected by parameters only.
- Adds data-enable, selectable sync polarity, line/frame strobes, a clock enable, and a sync-delay pipeline that aligns syncs with downstream pixel logic latency.
- Sits between the pixel-clock domain and the pattern/framebuffer logic driving the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs
- CNT_W, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- PIPE_DELAY, 0, extra cycles of delay on hs/vs/de relative to coordinates (0..7)

Ports:
- clk_vga  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel-clock enable; counters advance only when 1
- hs  out  1  horizontal sync, polarity HS_POL, delayed PIPE_DELAY
- vs  out  1  vertical sync, polarity VS_POL, delayed PIPE_DELAY
- de  out  1  display enable (hc<H_ACTIVE and vc<V_ACTIVE), delayed PIPE_DELAY
- hc_visible  out  CNT_W  x coordinate when in active region, else 0; undelayed
- vc_visible  out  CNT_W  y coordinate when in active region, else 0; undelayed
- line_start  out  1  one-cycle pulse while hc==0 (undelayed)
- frame_start  out  1  one-cycle pulse while hc==0 and vc==0 (undelayed)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- hc counts 0..H_TOTAL-1. On each clk_vga edge with en=1, hc increments; at H_TOTAL-1 it wraps to 0.
- vc increments only on the hc wrap; at V_TOTAL-1 it wraps to 0, in the same edge as the hc wrap. No count ever reaches H_TOTAL or V_TOTAL.
- en=0: hc and vc hold; all outputs hold their combinational value for the held count.
  - Strobes stay asserted while en=0 at hc==0. Consumers qualify strobes with en.
- Undelayed outputs are combinational from the registers:
  - hs_raw asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. It changes on line boundaries only.
  - de_raw = (hc<H_ACTIVE)&&(vc<V_ACTIVE).
  - hc_visible = de_raw ? hc : 0; vc_visible = de_raw ? vc : 0.
- Sync pipeline:
  - hs/vs/de pass through a PIPE_DELAY-stage shift register, advancing only when en=1.
  - PIPE_DELAY=0 gives a direct combinational path.
- Reset (rst_n low, asynchronous):
  - hc=vc=0; all pipeline stages load deasserted sync (~HS_POL, ~VS_POL) and de=0.
  - Released state: line_start=frame_start=1, hc_visible=vc_visible=0.
  - With PIPE_DELAY>0, de reads 0 until the pipeline fills.
  - Reset mid-frame restarts at pixel (0,0) with no partial sync pulse emitted after release.
- Arithmetic: all comparisons unsigned at CNT_W bits. Parameter sanity is checked at elaboration: a fatal error if H_TOTAL-1 or V_TOTAL-1 does not fit CNT_W, or if PIPE_DELAY>7.

Test Plan:
- Defaults, en=1, reset then run 2 frames:
  - Expected: hs low exactly for hc 656..751 (96 clk), period 800 clk.
  - Expected: vs low for vc 490..491, frame = 420000 clk.
  - Expected: de high 640 clk/line for lines 0..479.
- 1024x768@60 (H 1024/24/136/160, V 768/3/6/29):
  - Expected: line 1344 clk, frame 806 lines, hs low 136 clk starting at hc 1048.
- HS_POL=1, VS_POL=1:
  - Expected: pulses inverted vs defaults, same positions.
  - Expected: after reset, hs=0 and vs=0 before the first pulse.
- PIPE_DELAY=3:
  - Expected: hs/vs/de edges lag the PIPE_DELAY=0 run by exactly 3 clk.
  - Expected: coordinates and strobes are unchanged.
  - Expected: de=0 for the first 3 clk after reset.
- en toggling 1-0-1 pattern:
  - Expected: frame length doubles to 840000 clk.
  - Expected: hc holds during en=0; no hs pulse is lengthened beyond 2x96 clk.
- Assert rst_n low at hc=700, vc=300 for 5 clk:
  - Expected: outputs go to reset values immediately (asynchronous, not clock-aligned).
  - Expected: after release, frame_start=1 and the next hs low begins exactly 656 clk later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/timing generator with clock enable and sync delay pipeline
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int CNT_W      = 11,
  parameter int PIPE_DELAY = 0
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             en,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] hc_visible,
  output logic [CNT_W-1:0] vc_visible,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (H_TOTAL - 1 >= (1 << CNT_W)) begin : g_chk_h
    $fatal(1, "vga_timing_gen: H_TOTAL-1 does not fit CNT_W");
  end
  if (V_TOTAL - 1 >= (1 << CNT_W)) begin : g_chk_v
    $fatal(1, "vga_timing_gen: V_TOTAL-1 does not fit CNT_W");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_chk_pipe
    $fatal(1, "vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_vc;
  logic             w_hs;
  logic             w_vs;
  logic             w_de;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (en) begin
      if (r_hc == H_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? '0 : r_vc + CNT_W'(1);
      end else begin
        r_hc <= r_hc + CNT_W'(1);
      end
    end
  end

  assign w_hs = ((r_hc >= HS_BEG) && (r_hc < HS_END)) ? HS_ON : ~HS_ON;
  assign w_vs = ((r_vc >= VS_BEG) && (r_vc < VS_END)) ? VS_ON : ~VS_ON;
  assign w_de = (r_hc < H_ACT) && (r_vc < V_ACT);

  assign hc_visible  = w_de ? r_hc : '0;
  assign vc_visible  = w_de ? r_vc : '0;
  assign line_start  = (r_hc == '0);
  assign frame_start = (r_hc == '0) && (r_vc == '0);

  if (PIPE_DELAY == 0) begin : g_direct
    assign hs = w_hs;
    assign vs = w_vs;
    assign de = w_de;
  end else begin : g_pipe
    // Reset loads idle syncs so no partial pulse leaks out after release.
    logic [2:0] r_pipe [PIPE_DELAY];

    always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          r_pipe[i] <= {~HS_ON, ~VS_ON, 1'b0};
        end
      end else if (en) begin
        r_pipe[0] <= {w_hs, w_vs, w_de};
        for (int i = 1; i < PIPE_DELAY; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign hs = r_pipe[PIPE_DELAY-1][2];
    assign vs = r_pipe[PIPE_DELAY-1][1];
    assign de = r_pipe[PIPE_DELAY-1][0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, en_a, en_b;

  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] hcv_a, vcv_a;
  logic        hs_c, vs_c, de_c, ls_c, fs_c;
  logic [10:0] hcv_c, vcv_c;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0]  hcv_b, vcv_b;
  logic [12:0] obs_b;

  assign obs_b = {hs_b, vs_b, de_b, ls_b, fs_b, hcv_b, vcv_b};

  vga_timing_gen u_a (
    .clk_vga(clk), .rst_n(rst_a), .en(en_a),
    .hs(hs_a), .vs(vs_a), .de(de_a),
    .hc_visible(hcv_a), .vc_visible(vcv_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
    .V_ACTIVE(768), .V_FP(3), .V_SYNC(6), .V_BP(29)
  ) u_c (
    .clk_vga(clk), .rst_n(rst_a), .en(en_a),
    .hs(hs_c), .vs(vs_c), .de(de_c),
    .hc_visible(hcv_c), .vc_visible(vcv_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  // Small mode: H 8/2/3/2 (15), V 4/1/2/1 (8), positive syncs, 3-stage delay.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(4), .PIPE_DELAY(3)
  ) u_b (
    .clk_vga(clk), .rst_n(rst_b), .en(en_b),
    .hs(hs_b), .vs(vs_b), .de(de_b),
    .hc_visible(hcv_b), .vc_visible(vcv_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected small-mode outputs after m enabled edges since reset release.
  function automatic logic [12:0] exp_b(input int m);
    int hc, vc, dh, dv;
    logic h, v, d, act;
    hc = m % 15;
    vc = (m / 15) % 8;
    h = 1'b0; v = 1'b0; d = 1'b0;
    if (m >= 3) begin
      dh = (m - 3) % 15;
      dv = ((m - 3) / 15) % 8;
      h  = (dh >= 10) && (dh < 13);
      v  = (dv >= 5) && (dv < 7);
      d  = (dh < 8) && (dv < 4);
    end
    act = (hc < 8) && (vc < 4);
    return {h, v, d, (hc == 0), (hc == 0 && vc == 0),
            act ? 4'(hc) : 4'd0, act ? 4'(vc) : 4'd0};
  endfunction

  initial begin
    int hs_low, de_hi, ls_cnt, fs_cnt, vs_low, hsc_low, n, m;

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_hs", hs_a, 1);
    chk("a_rst_vs", vs_a, 1);
    chk("a_rst_ls", ls_a, 1);
    chk("a_rst_fs", fs_a, 1);
    chk("a_rst_hcv", hcv_a, 0);

    rst_a = 1'b1;
    hs_low = 0; de_hi = 0; ls_cnt = 0; fs_cnt = 0; vs_low = 0; hsc_low = 0;
    for (int k = 0; k < 1600; k++) begin
      if (hs_a === 1'b0) hs_low++;
      if (de_a === 1'b1) de_hi++;
      if (ls_a === 1'b1) ls_cnt++;
      if (fs_a === 1'b1) fs_cnt++;
      if (vs_a === 1'b0) vs_low++;
      if (hs_c === 1'b0) hsc_low++;
      if (k == 655 || k == 752 || k == 1455 || k == 1552) chk("a_hs_idle", hs_a, 1);
      if (k == 656 || k == 751 || k == 1456 || k == 1551) chk("a_hs_act", hs_a, 0);
      if (k == 639) chk("a_de_last", de_a, 1);
      if (k == 640) chk("a_de_off", de_a, 0);
      if (k == 100) chk("a_hcv_100", hcv_a, 100);
      if (k == 700) chk("a_hcv_blank", hcv_a, 0);
      if (k == 900) chk("a_vcv_line1", vcv_a, 1);
      if (k == 900) chk("a_hcv_line1", hcv_a, 100);
      if (k == 1047 || k == 1184) chk("c_hs_idle", hs_c, 1);
      if (k == 1048 || k == 1183) chk("c_hs_act", hs_c, 0);
      if (k == 1343) chk("c_ls_pre", ls_c, 0);
      if (k == 1344) chk("c_ls_wrap", ls_c, 1);
      if (k == 1349) chk("c_vcv_line1", vcv_c, 1);
      step();
    end
    chk("a_hs_low_cnt", hs_low, 192);
    chk("a_de_hi_cnt", de_hi, 1280);
    chk("a_ls_cnt", ls_cnt, 2);
    chk("a_fs_cnt", fs_cnt, 1);
    chk("a_vs_low_cnt", vs_low, 0);
    chk("c_hs_low_cnt", hsc_low, 136);

    repeat (700) step();
    chk("a_hs_pre_rst", hs_a, 0);
    #3;
    rst_a = 1'b0;
    #1;
    chk("a_async_hs", hs_a, 1);
    chk("a_async_ls", ls_a, 1);
    chk("a_async_fs", fs_a, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_a = 1'b1;
    chk("a_rel_fs", fs_a, 1);
    chk("a_rel_hcv", hcv_a, 0);
    n = 0;
    while (n < 2000 && hs_a !== 1'b0) begin
      step();
      n++;
    end
    chk("a_rel_hs_delay", n, 656);

    chk("b_rst_hs", hs_b, 0);
    chk("b_rst_vs", vs_b, 0);
    chk("b_rst_vec", obs_b, exp_b(0));
    rst_b = 1'b1;
    m = 0;
    for (int i = 0; i < 240; i++) begin
      chk("b_run", obs_b, exp_b(m));
      @(posedge clk);
      m++;
      #1;
    end
    for (int i = 0; i < 480; i++) begin
      chk("b_en_toggle", obs_b, exp_b(m));
      en_b = (i % 2 == 1);
      @(posedge clk);
      if (en_b) m++;
      #1;
    end
    en_b = 1'b1;
    chk("b_toggle_m", m, 480);
    chk("b_toggle_fs", fs_b, 1);

    repeat (44) begin
      step();
      m++;
    end
    chk("b_pre_rst_vec", obs_b, exp_b(m));
    chk("b_pre_rst_hs", hs_b, 1);
    #3;
    rst_b = 1'b0;
    #1;
    chk("b_async_hs", hs_b, 0);
    chk("b_async_de", de_b, 0);
    chk("b_async_fs", fs_b, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_b = 1'b1;
    m = 0;
    for (int i = 0; i < 30; i++) begin
      chk("b_after_rst", obs_b, exp_b(m));
      @(posedge clk);
      m++;
      #1;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
